// File: rtl/i2c_config_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer: state codes,
// 24-bit word field layout and the write-direction constant.
package i2c_cfg_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_POWERUP  = 4'd1;
    localparam logic [3:0] ST_LOAD     = 4'd2;
    localparam logic [3:0] ST_ISSUE    = 4'd3;
    localparam logic [3:0] ST_WAIT_END = 4'd4;
    localparam logic [3:0] ST_CHECK    = 4'd5;
    localparam logic [3:0] ST_GAP      = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;
    localparam logic [3:0] ST_FAIL     = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_POWERUP  = ST_POWERUP,
        S_LOAD     = ST_LOAD,
        S_ISSUE    = ST_ISSUE,
        S_WAIT_END = ST_WAIT_END,
        S_CHECK    = ST_CHECK,
        S_GAP      = ST_GAP,
        S_DONE     = ST_DONE,
        S_FAIL     = ST_FAIL
    } state_t;

    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 16;
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic W_R_WRITE = 1'b0;

    function automatic logic [23:0] make_word(input logic [7:0] addr,
                                              input logic [7:0] regnum,
                                              input logic [7:0] value);
        logic [23:0] w;
        w = '0;
        w[ADDR_MSB:ADDR_LSB] = addr;
        w[REG_MSB:REG_LSB]   = regnum;
        w[DATA_MSB:DATA_LSB] = value;
        return w;
    endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Handshake between the configuration sequencer (master) and I2C_Controller (slave).
interface i2c_config_sequencer_if;
    logic [23:0] I2C_DATA;
    logic        GO;
    logic        W_R;
    logic        END;
    logic        ACK;

    modport master (output I2C_DATA, output GO, output W_R, input END, input ACK);
    modport slave  (input I2C_DATA, input GO, input W_R, output END, output ACK);
endinterface

// File: rtl/i2c_config_rom.sv
// Power-up register table: combinational lookup of {slave_addr, reg, data}
// words by index; entries past the table read as zero.
module i2c_config_rom
    import i2c_cfg_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [IDX_W-1:0] index,
    output logic [23:0]      word
);

    always_comb begin
        word = '0;
        case (int'(index))
            0:  word = make_word(8'h34, 8'h1E, 8'h00);
            1:  word = make_word(8'h34, 8'h00, 8'h17);
            2:  word = make_word(8'h34, 8'h02, 8'h17);
            3:  word = make_word(8'h34, 8'h04, 8'h79);
            4:  word = make_word(8'h34, 8'h06, 8'h79);
            5:  word = make_word(8'h34, 8'h08, 8'h12);
            6:  word = make_word(8'h34, 8'h0A, 8'h06);
            7:  word = make_word(8'h34, 8'h0C, 8'h00);
            8:  word = make_word(8'h34, 8'h0E, 8'h42);
            9:  word = make_word(8'h34, 8'h10, 8'h02);
            10: word = make_word(8'h34, 8'h12, 8'h01);
            11: word = make_word(8'h42, 8'h01, 8'h80);
            12: word = make_word(8'h42, 8'h02, 8'h10);
            13: word = make_word(8'h42, 8'h03, 8'h00);
            14: word = make_word(8'h42, 8'h04, 8'h55);
            15: word = make_word(8'h42, 8'h05, 8'hAA);
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the register table after power-up, hands each word to I2C_Controller,
// retries NACKed words and reports DONE / ERROR.
module i2c_config_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 16,
    parameter int IDX_W          = 8,
    parameter int POWERUP_CYCLES = 50000,
    parameter int GAP_CYCLES     = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    output logic [IDX_W-1:0]      LUT_INDEX,
    input  logic [23:0]           LUT_DATA,
    i2c_config_sequencer_if.master bus,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [IDX_W-1:0]      ERR_INDEX
);

    localparam int PWR_W = (POWERUP_CYCLES > 0) ? $clog2(POWERUP_CYCLES + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t             state, state_nxt;
    logic [PWR_W-1:0]   pwr_cnt, pwr_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [RTY_W-1:0]   retry_cnt, retry_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [IDX_W-1:0]   err_idx_q, err_idx_nxt;
    logic [23:0]        data_q, data_nxt;
    logic               nack_q, nack_nxt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_POWERUP;
            pwr_cnt   <= '0;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            idx_q     <= '0;
            err_idx_q <= '0;
            data_q    <= '0;
            nack_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pwr_cnt   <= pwr_nxt;
            gap_cnt   <= gap_nxt;
            retry_cnt <= retry_nxt;
            idx_q     <= idx_nxt;
            err_idx_q <= err_idx_nxt;
            data_q    <= data_nxt;
            nack_q    <= nack_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pwr_nxt     = pwr_cnt;
        gap_nxt     = gap_cnt;
        retry_nxt   = retry_cnt;
        idx_nxt     = idx_q;
        err_idx_nxt = err_idx_q;
        data_nxt    = data_q;
        nack_nxt    = nack_q;
        case (state)
            S_POWERUP: begin
                if (32'(pwr_cnt) + 32'd1 >= 32'(POWERUP_CYCLES)) begin
                    pwr_nxt   = '0;
                    state_nxt = S_LOAD;
                end else begin
                    pwr_nxt = pwr_cnt + PWR_W'(1);
                end
            end
            S_LOAD: begin
                data_nxt  = LUT_DATA;
                retry_nxt = '0;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!bus.END) state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (bus.END) begin
                    nack_nxt  = bus.ACK;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!nack_q) begin
                    if (32'(idx_q) == 32'(NUM_REGS - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_q + IDX_W'(1);
                        state_nxt = S_GAP;
                    end
                end else if (32'(retry_cnt) < 32'(MAX_RETRY)) begin
                    retry_nxt = retry_cnt + RTY_W'(1);
                    state_nxt = S_GAP;
                end else begin
                    err_idx_nxt = idx_q;
                    state_nxt   = S_FAIL;
                end
            end
            // A retried word skips LOAD so the held I2C_DATA is resent unchanged.
            S_GAP: begin
                if (32'(gap_cnt) + 32'd1 >= 32'(GAP_CYCLES)) begin
                    gap_nxt   = '0;
                    state_nxt = nack_q ? S_ISSUE : S_LOAD;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            S_DONE, S_FAIL: begin
                if (START) begin
                    idx_nxt     = '0;
                    err_idx_nxt = '0;
                    state_nxt   = S_POWERUP;
                end
            end
            default: state_nxt = S_POWERUP;
        endcase
    end

    assign bus.GO       = (state == S_WAIT_END);
    assign bus.I2C_DATA = data_q;
    assign bus.W_R      = W_R_WRITE;
    assign LUT_INDEX    = idx_q;
    assign ERR_INDEX    = err_idx_q;
    assign BUSY         = (state != S_DONE) && (state != S_FAIL);
    assign DONE         = (state == S_DONE);
    assign ERROR        = (state == S_FAIL);

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for the configuration sequencer with a small I2C_Controller
// model that can NACK a chosen table word.
module tb_i2c_config_sequencer;

    localparam int NUM_REGS = 4;
    localparam int IDX_W    = 8;
    localparam int PWR      = 20;
    localparam int GAP      = 5;
    localparam int RETRY    = 3;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b0;
    logic             START = 1'b0;
    logic [IDX_W-1:0] lut_index;
    logic [23:0]      lut_data;
    logic             BUSY, DONE, ERROR;
    logic [IDX_W-1:0] ERR_INDEX;

    i2c_config_sequencer_if bus_if();

    i2c_config_rom #(.IDX_W(IDX_W)) rom (.index(lut_index), .word(lut_data));

    i2c_config_sequencer #(
        .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .POWERUP_CYCLES(PWR),
        .GAP_CYCLES(GAP), .MAX_RETRY(RETRY)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .LUT_INDEX(lut_index), .LUT_DATA(lut_data), .bus(bus_if.master),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_INDEX(ERR_INDEX)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;

    logic [23:0] rom_exp [0:3];

    bit          slave_en = 1'b1;
    int          lat_cnt = 0;
    int          nack_left = 0;
    logic [23:0] nack_data = '0;

    int          n_sends = 0;
    int          send_idx [0:63];
    logic [23:0] send_data [0:63];
    int          send_low [0:63];
    int          low_cnt = 0;
    bit          go_prev = 1'b0;
    logic [23:0] held_data = '0;
    int          unstable = 0;

    // Controller model: answers each GO after a few cycles with a one-cycle END.
    always @(negedge CLOCK) begin
        if (slave_en) begin
            if (bus_if.END) begin
                bus_if.END = 1'b0;
                bus_if.ACK = 1'b0;
            end else if (bus_if.GO) begin
                if (lat_cnt >= 2) begin
                    lat_cnt = 0;
                    bus_if.END = 1'b1;
                    if (nack_left > 0 && bus_if.I2C_DATA == nack_data) begin
                        bus_if.ACK = 1'b1;
                        nack_left--;
                    end else begin
                        bus_if.ACK = 1'b0;
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (bus_if.GO && !go_prev && n_sends < 64) begin
            send_idx[n_sends]  = int'(lut_index);
            send_data[n_sends] = bus_if.I2C_DATA;
            send_low[n_sends]  = low_cnt;
            held_data          = bus_if.I2C_DATA;
            n_sends++;
        end
        if (bus_if.GO && bus_if.I2C_DATA !== held_data) unstable++;
        low_cnt = bus_if.GO ? 0 : low_cnt + 1;
        go_prev = bus_if.GO;
    end

    task automatic do_reset();
        RESET = 1'b0;
        START = 1'b0;
        bus_if.END = 1'b0;
        bus_if.ACK = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic measure_go(output int k);
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge CLOCK); #1;
            if (bus_if.GO) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_finish(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLOCK); #1;
            if (DONE || ERROR) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int k;
        RESET = 1'b0;
        bus_if.END = 1'b0;
        bus_if.ACK = 1'b0;
        #12;
        checks++;
        if (bus_if.GO !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0 || ERROR !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got go=%b busy=%b done=%b error=%b expected 0 1 0 0",
                     bus_if.GO, BUSY, DONE, ERROR);
        end
        checks++;
        if (lut_index !== 8'd0 || ERR_INDEX !== 8'd0 || bus_if.I2C_DATA !== 24'd0 || bus_if.W_R !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_regs: got idx=%0h err_idx=%0h data=%0h w_r=%b expected all 0",
                     lut_index, ERR_INDEX, bus_if.I2C_DATA, bus_if.W_R);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        measure_go(k);
        checks++;
        if (k != PWR + 2) begin
            failures++;
            $display("[TB] FAIL first_go_latency: got %0d expected %0d", k, PWR + 2);
        end
    endtask

    task automatic test_all_ack();
        int base;
        bit ok;
        do_reset();
        base = n_sends;
        wait_finish(ok);
        checks++;
        if (!ok || n_sends - base != 4) begin
            failures++;
            $display("[TB] FAIL all_ack_sends: got %0d expected 4 (finished=%0d)", n_sends - base, ok);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (send_idx[base + i] != i || send_data[base + i] !== rom_exp[i]) begin
                failures++;
                $display("[TB] FAIL all_ack_word%0d: got idx=%0d data=%0h expected idx=%0d data=%0h",
                         i, send_idx[base + i], send_data[base + i], i, rom_exp[i]);
            end
        end
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || ERROR !== 1'b0 || unstable != 0) begin
            failures++;
            $display("[TB] FAIL all_ack_status: got done=%b busy=%b error=%b unstable=%0d expected 1 0 0 0",
                     DONE, BUSY, ERROR, unstable);
        end
        checks++;
        if (send_low[base + 1] != GAP + 3) begin
            failures++;
            $display("[TB] FAIL ack_gap: got %0d expected %0d", send_low[base + 1], GAP + 3);
        end
    endtask

    task automatic test_nack_once();
        int base;
        bit ok;
        int exp_idx [0:4];
        exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 2; exp_idx[4] = 3;
        do_reset();
        nack_data = rom_exp[2];
        nack_left = 1;
        base = n_sends;
        wait_finish(ok);
        checks++;
        if (!ok || n_sends - base != 5) begin
            failures++;
            $display("[TB] FAIL nack_once_sends: got %0d expected 5", n_sends - base);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (send_idx[base + i] != exp_idx[i] || send_data[base + i] !== rom_exp[exp_idx[i]]) begin
                failures++;
                $display("[TB] FAIL nack_once_word%0d: got idx=%0d data=%0h expected idx=%0d data=%0h",
                         i, send_idx[base + i], send_data[base + i], exp_idx[i], rom_exp[exp_idx[i]]);
            end
        end
        checks++;
        if (send_low[base + 3] != GAP + 2) begin
            failures++;
            $display("[TB] FAIL retry_gap: got %0d expected %0d", send_low[base + 3], GAP + 2);
        end
        checks++;
        if (DONE !== 1'b1 || ERROR !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nack_once_status: got done=%b error=%b expected 1 0", DONE, ERROR);
        end
        nack_left = 0;
    endtask

    task automatic test_nack_exhaust();
        int base;
        int cnt1;
        int cnt2;
        bit ok;
        do_reset();
        nack_data = rom_exp[1];
        nack_left = 1000;
        base = n_sends;
        wait_finish(ok);
        cnt1 = 0;
        cnt2 = 0;
        for (int i = base; i < n_sends; i++) begin
            if (send_idx[i] == 1) cnt1++;
            if (send_idx[i] == 2) cnt2++;
        end
        checks++;
        if (!ok || cnt1 != RETRY + 1 || cnt2 != 0) begin
            failures++;
            $display("[TB] FAIL exhaust_sends: got idx1=%0d idx2=%0d expected %0d 0", cnt1, cnt2, RETRY + 1);
        end
        checks++;
        if (ERROR !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0 || ERR_INDEX !== 8'd1) begin
            failures++;
            $display("[TB] FAIL exhaust_status: got error=%b done=%b busy=%b err_idx=%0d expected 1 0 0 1",
                     ERROR, DONE, BUSY, ERR_INDEX);
        end
        nack_left = 0;
        @(negedge CLOCK);
        START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        checks++;
        if (ERROR !== 1'b0 || ERR_INDEX !== 8'd0 || BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fail_restart: got error=%b err_idx=%0d busy=%b expected 0 0 1",
                     ERROR, ERR_INDEX, BUSY);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit seen;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge CLOCK); #1;
            if (bus_if.GO && lut_index == 8'd3) begin
                seen = 1'b1;
                break;
            end
        end
        #1 RESET = 1'b0;
        #1;
        checks++;
        if (!seen || bus_if.GO !== 1'b0 || lut_index !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_go: got seen=%0d go=%b idx=%0d expected 1 0 0", seen, bus_if.GO, lut_index);
        end
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        measure_go(k);
        checks++;
        if (k != PWR + 2 || lut_index !== 8'd0 || bus_if.I2C_DATA !== rom_exp[0]) begin
            failures++;
            $display("[TB] FAIL reset_mid_restart: got lat=%0d idx=%0d data=%0h expected %0d 0 %0h",
                     k, lut_index, bus_if.I2C_DATA, PWR + 2, rom_exp[0]);
        end
    endtask

    task automatic test_start();
        int k;
        int base;
        bit ok;
        do_reset();
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge CLOCK); #1;
            START = (i == 5);
            if (bus_if.GO) begin
                k = i;
                break;
            end
        end
        START = 1'b0;
        checks++;
        if (k != PWR + 2) begin
            failures++;
            $display("[TB] FAIL start_busy_ignored: got latency %0d expected %0d", k, PWR + 2);
        end
        wait_finish(ok);
        @(negedge CLOCK);
        START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        checks++;
        if (!ok || DONE !== 1'b0 || BUSY !== 1'b1 || lut_index !== 8'd0) begin
            failures++;
            $display("[TB] FAIL start_clear: got done=%b busy=%b idx=%0d expected 0 1 0", DONE, BUSY, lut_index);
        end
        base = n_sends;
        measure_go(k);
        checks++;
        if (k != PWR + 2) begin
            failures++;
            $display("[TB] FAIL start_latency: got %0d expected %0d", k, PWR + 2);
        end
        wait_finish(ok);
        checks++;
        if (!ok || DONE !== 1'b1 || n_sends - base != 4 || send_data[base + 3] !== rom_exp[3]) begin
            failures++;
            $display("[TB] FAIL start_resend: got done=%b sends=%0d last=%0h expected 1 4 %0h",
                     DONE, n_sends - base, send_data[base + 3], rom_exp[3]);
        end
    endtask

    task automatic test_end_high();
        int base;
        bit ok;
        slave_en = 1'b0;
        do_reset();
        bus_if.END = 1'b1;
        bus_if.ACK = 1'b1;
        base = n_sends;
        repeat (PWR + 10) @(posedge CLOCK);
        #1;
        checks++;
        if (bus_if.GO !== 1'b0 || n_sends != base || BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL end_high_hold: got go=%b sends=%0d busy=%b expected 0 0 1",
                     bus_if.GO, n_sends - base, BUSY);
        end
        @(negedge CLOCK);
        bus_if.END = 1'b0;
        bus_if.ACK = 1'b0;
        @(posedge CLOCK); #1;
        checks++;
        if (bus_if.GO !== 1'b1) begin
            failures++;
            $display("[TB] FAIL end_fall_go: got %b expected 1", bus_if.GO);
        end
        @(negedge CLOCK);
        bus_if.END = 1'b1;
        @(posedge CLOCK); #1;
        checks++;
        if (bus_if.GO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL end_done_go: got %b expected 0", bus_if.GO);
        end
        @(negedge CLOCK);
        bus_if.END = 1'b0;
        slave_en = 1'b1;
        wait_finish(ok);
        checks++;
        if (!ok || DONE !== 1'b1 || n_sends - base != 4 || send_idx[base + 1] != 1) begin
            failures++;
            $display("[TB] FAIL end_high_finish: got done=%b sends=%0d idx1=%0d expected 1 4 1",
                     DONE, n_sends - base, send_idx[base + 1]);
        end
    endtask

    initial begin
        rom_exp[0] = 24'h341E00;
        rom_exp[1] = 24'h340017;
        rom_exp[2] = 24'h340217;
        rom_exp[3] = 24'h340479;
        bus_if.END = 1'b0;
        bus_if.ACK = 1'b0;
        test_reset();
        test_all_ack();
        test_nack_once();
        test_nack_exhaust();
        test_reset_mid();
        test_start();
        test_end_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
